// File: rtl/uart_tx_arb.sv
// Arbiter that picks one of NUM_REQ requesters and launches its byte into a UART transmitter.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module uart_tx_arb #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    input  logic                          tx_busy,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_data_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic [ID_W-1:0]   grant_id_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              err_nxt;
    logic              any_req;
    logic [ID_W-1:0]   winner;

    function automatic logic [ID_W-1:0] wrap_idx(input int i);
        return ID_W'(i % NUM_REQ);
    endfunction

    assign any_req = |req_valid;

`ifdef UART_TX_ARB_RR_EN
    logic [ID_W-1:0] ptr, ptr_nxt;

    // Walk backwards so the first valid requester after the pointer is the last one written.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(int'(ptr) + 1 + k)]) begin
                winner = wrap_idx(int'(ptr) + 1 + k);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(k)]) begin
                winner = wrap_idx(k);
            end
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        tx_data_nxt  = tx_data;
        grant_id_nxt = grant_id;
        cnt_nxt      = cnt;
        err_nxt      = 1'b0;
`ifdef UART_TX_ARB_RR_EN
        ptr_nxt      = ptr;
`endif
        case (state)
            IDLE: begin
                if (any_req) begin
                    tx_data_nxt  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
                    grant_id_nxt = winner;
                    state_nxt    = LAUNCH;
`ifdef UART_TX_ARB_RR_EN
                    ptr_nxt      = winner;
`endif
                end
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // cnt holds the number of earlier idle WAIT_BUSY cycles, so CNT_LAST marks the final one.
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ack = '0;
        if (state == LAUNCH) begin
            req_ack[grant_id] = 1'b1;
        end
    end

    assign tx_data_valid = (state == LAUNCH);
    assign arb_busy      = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            tx_data     <= '0;
            grant_id    <= LAST_ID;
            cnt         <= '0;
            err_timeout <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
            ptr         <= LAST_ID;
`endif
        end else begin
            state       <= state_nxt;
            tx_data     <= tx_data_nxt;
            grant_id    <= grant_id_nxt;
            cnt         <= cnt_nxt;
            err_timeout <= err_nxt;
`ifdef UART_TX_ARB_RR_EN
            ptr         <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized scoreboard bench for uart_tx_arb; follows UART_TX_ARB_RR_EN to choose the arbitration model.
module tb_uart_tx_arb;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct {
        int             id;
        logic [DW-1:0]  data;
        bit             to;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ack;
    logic              tx_busy;
    logic [DW-1:0]     tx_data;
    logic              tx_data_valid;
    logic [1:0]        grant_id;
    logic              arb_busy;
    logic              err_timeout;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_ptr = N - 1;
    int   cycle = 0;
    int   last_launch = -100;
    bit   pend_to = 1'b0;
    logic rst_q = 1'b1;

    uart_tx_arb #(.DATA_WIDTH(DW), .NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .grant_id(grant_id),
        .arb_busy(arb_busy), .err_timeout(err_timeout)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rst_q <= RST;

    // Winner chosen from the current request set and the index of the last grant.
    function automatic int model_pick(input logic [N-1:0] vec);
`ifdef UART_TX_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (vec[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (vec[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_expect(input logic [N-1:0] vec, input logic [N*DW-1:0] dat, input bit to, output int w);
        exp_t e;
        w = model_pick(vec);
        e.id = w;
        e.data = dat[w*DW +: DW];
        e.to = to;
        exp_q.push_back(e);
        model_ptr = w;
    endtask

    task automatic wait_launch(output bit seen, output int n);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            n++;
            if (tx_data_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL launch_wait: got no tx_data_valid expected a launch");
            if (exp_q.size() != 0) void'(exp_q.pop_back());
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!arb_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_wait: got arb_busy=1 expected 0");
        end
    endtask

    // Transmitter model: busy seen on WAIT_BUSY cycle d after launch, held for b cycles.
    task automatic serve(input int d, input int b);
        if (d <= TO) begin
            repeat (d - 1) @(negedge CLK);
            tx_busy = 1'b1;
            repeat (b) @(negedge CLK);
            tx_busy = 1'b0;
        end else begin
            tx_busy = 1'b0;
        end
        wait_idle();
    endtask

    task automatic apply_stimulus(input logic [N-1:0] vec, input logic [N*DW-1:0] dat,
                                  input int d, input int b, input bit pre_busy);
        int w, n;
        bit seen;
        push_expect(vec, dat, (d > TO), w);
        req_data = dat;
        req_valid = vec;
        if (pre_busy) tx_busy = 1'b1;
        wait_launch(seen, n);
        req_valid = '0;
        if (seen) serve(d, b);
        else tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req_valid = '0;
        tx_busy = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_ptr = N - 1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_tx_data"}, tx_data, 0);
        check_output({tag, "_tx_data_valid"}, tx_data_valid, 0);
        check_output({tag, "_req_ack"}, req_ack, 0);
        check_output({tag, "_grant_id"}, grant_id, N - 1);
        check_output({tag, "_arb_busy"}, arb_busy, 0);
        check_output({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    // Monitor: pops one expectation per launch and checks timeout pulses and ack hygiene.
    initial begin
        exp_t e;
        bit exp_err;
        forever begin
            @(negedge CLK);
            cycle++;
            if (rst_q) begin
                pend_to = 1'b0;
                last_launch = -100;
            end else begin
                exp_err = pend_to && (cycle - last_launch == TO + 1);
                if (err_timeout || exp_err) begin
                    check_output("err_timeout", err_timeout, exp_err);
                    pend_to = 1'b0;
                end
                if (tx_data_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_launch: got grant_id=%0d expected no launch", grant_id);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("grant_id", grant_id, e.id);
                        check_output("tx_data", tx_data, e.data);
                        check_output("req_ack", req_ack, 32'(1) << e.id);
                        if (last_launch > -100) begin
                            total++;
                            if (cycle - last_launch < 4) begin
                                bad++;
                                $display("[TB] FAIL launch_spacing: got %0d expected >=4", cycle - last_launch);
                            end
                        end
                        pend_to = e.to;
                    end
                    last_launch = cycle;
                end else if (req_ack !== '0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL stray_ack: got %0h expected 0", req_ack);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N*DW-1:0] dat;
        int w, n, d, b;
        bit seen, pre;

        RST = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_busy = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        RST = 1'b0;

        // Single request from requester 2.
        dat = $urandom;
        dat[23:16] = 8'hA5;
        apply_stimulus(4'b0100, dat, 2, 10, 1'b0);
        check_output("hold_grant_id", grant_id, 2);
        check_output("hold_tx_data", tx_data, 8'hA5);
        check_output("idle_arb_busy", arb_busy, 0);

        // All four requesters held.
        do_reset();
        dat = $urandom;
        req_data = dat;
        req_valid = '1;
        for (int f = 0; f < 5; f++) push_expect('1, dat, 1'b0, w);
        for (int f = 0; f < 5; f++) begin
            wait_launch(seen, n);
            if (f == 4) req_valid = '0;
            if (!seen) break;
            serve(1, 2);
        end
        req_valid = '0;

        // Back-to-back 3-cycle frames from requester 1.
        dat = $urandom;
        req_data = dat;
        req_valid = 4'b0010;
        for (int f = 0; f < 4; f++) push_expect(4'b0010, dat, 1'b0, w);
        for (int f = 0; f < 4; f++) begin
            wait_launch(seen, n);
            if (f > 0) check_output("b2b_regrant_delay", n, 1);
            if (f == 3) req_valid = '0;
            if (!seen) break;
            serve(1, 2);
        end
        req_valid = '0;

        // Timeout followed by the next pending requester.
        do_reset();
        dat = $urandom;
        req_data = dat;
        req_valid = 4'b0101;
        push_expect(4'b0101, dat, 1'b1, w);
        push_expect(4'b0101 & ~(4'b0001 << w), dat, 1'b0, n);
        wait_launch(seen, n);
        req_valid[w] = 1'b0;
        wait_launch(seen, n);
        check_output("timeout_relaunch_delay", n, TO + 2);
        req_valid = '0;
        if (seen) serve(1, 2);

        // Reset while in WAIT_DONE.
        dat = $urandom;
        req_data = dat;
        req_valid = 4'b0001;
        push_expect(4'b0001, dat, 1'b0, w);
        wait_launch(seen, n);
        req_valid = '0;
        tx_busy = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_ptr = N - 1;
        check_reset_values("midreset");
        tx_busy = 1'b0;
        repeat (12) @(negedge CLK);
        check_output("midreset_idle", arb_busy, 0);

        // Requester 3 withdraws before it could be granted.
        dat = $urandom;
        req_data = dat;
        req_valid = 4'b0001;
        push_expect(4'b0001, dat, 1'b0, w);
        wait_launch(seen, n);
        req_valid = '0;
        tx_busy = 1'b1;
        repeat (2) @(negedge CLK);
        req_valid[3] = 1'b1;
        @(negedge CLK);
        req_valid[3] = 1'b0;
        repeat (2) @(negedge CLK);
        tx_busy = 1'b0;
        wait_idle();
        repeat (10) @(negedge CLK);

        // tx_busy high while idle must not stall arbitration.
        apply_stimulus(4'b1000, $urandom, 1, 3, 1'b1);

        for (int f = 0; f < 30; f++) begin
            d = $urandom_range(1, 3);
            if ($urandom_range(0, 5) == 0) d = TO + 1;
            b = $urandom_range(2, 6);
            pre = ($urandom_range(0, 7) == 0) && (d <= TO);
            apply_stimulus(4'($urandom_range(1, 15)), $urandom, d, b, pre);
        end

        repeat (12) @(negedge CLK);
        check_output("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
